// File: rtl/a2wb_pkg.sv
// Constants shared between the core-to-bus bridge and its Wishbone memory target:
// extended command encodings, response bit positions, reservation granule and FSM states.
package a2wb_pkg;

    localparam logic [7:0] EXT_CMD_NORMAL = 8'h00;
    localparam logic [7:0] EXT_CMD_LARX   = 8'h01;
    localparam logic [7:0] EXT_CMD_STCX   = 8'h02;

    localparam int EXT_RSP_PASS_BIT = 0;
    localparam int EXT_RSP_ERR_BIT  = 1;

    // Reservation granule is 2^RESV_GRAN_BITS bytes.
    localparam int RESV_GRAN_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TERM = 2'd2
    } tgt_state_t;

endpackage

// File: rtl/wb_mem_target_if.sv
// Wishbone classic bus plus the bridge's 8-bit extended command/response sideband.
interface wb_mem_target_if;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_datw;
    logic [7:0]  ext_cmd;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_datr;
    logic [7:0]  ext_rsp;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_datw, ext_cmd,
        input  wb_ack, wb_err, wb_datr, ext_rsp
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_datw, ext_cmd,
        output wb_ack, wb_err, wb_datr, ext_rsp
    );

endinterface

// File: rtl/wb_sram_bytewe.sv
// Single-port SRAM with per-byte write enables and a registered read port.
// The read register returns 0 in any cycle that follows a non-read access.
module wb_sram_bytewe #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem_q [2**ADDR_BITS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Byte-lane array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is forced to zero when no read is performed.
    always_comb begin
        rdata_d = 32'h0000_0000;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0000_0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_mem_target.sv
// Wishbone B4 classic responder fronting an on-chip SRAM, with wait states,
// out-of-range error termination and a single larx/stcx reservation.
module wb_mem_target
    import a2wb_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    wb_mem_target_if.slave  bus
);

    localparam int         GRAN_W  = 32 - RESV_GRAN_BITS;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    tgt_state_t        state_d, state_q;
    logic [3:0]        cnt_d, cnt_q;
    logic              we_d, we_q;
    logic [3:0]        sel_d, sel_q;
    logic [31:2]       adr_d, adr_q;
    logic [31:0]       datw_d, datw_q;
    logic [7:0]        cmd_d, cmd_q;
    logic              resv_valid_d, resv_valid_q;
    logic [GRAN_W-1:0] resv_gran_d, resv_gran_q;
    logic              ack_d, ack_q;
    logic              err_d, err_q;
    logic [7:0]        rsp_d, rsp_q;

    logic        req_s, go_term_s, in_range_s, resv_hit_s, pass_s;
    logic        cur_we_s;
    logic [3:0]  cur_sel_s;
    logic [31:2] cur_adr_s;
    logic [31:0] cur_datw_s;
    logic [7:0]  cur_cmd_s;
    logic        sram_en_s;
    logic [31:0] sram_rdata_s;

    // Next-state, request capture, range check, commit and reservation update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        datw_d       = datw_q;
        cmd_d        = cmd_q;
        resv_valid_d = resv_valid_q;
        resv_gran_d  = resv_gran_q;
        go_term_s    = 1'b0;
        sram_en_s    = 1'b0;
        pass_s       = 1'b0;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rsp_d        = 8'h00;
        req_s        = bus.wb_cyc & bus.wb_stb;

        // With zero wait states the commit edge is the accept edge, so use live inputs.
        if (state_q == ST_IDLE) begin
            cur_we_s   = bus.wb_we;
            cur_sel_s  = bus.wb_sel;
            cur_adr_s  = bus.wb_adr[31:2];
            cur_datw_s = bus.wb_datw;
            cur_cmd_s  = bus.ext_cmd;
        end else begin
            cur_we_s   = we_q;
            cur_sel_s  = sel_q;
            cur_adr_s  = adr_q;
            cur_datw_s = datw_q;
            cur_cmd_s  = cmd_q;
        end

        in_range_s = (cur_adr_s[31:ADDR_BITS+2] == BASE_ADR[31:ADDR_BITS+2]);
        resv_hit_s = resv_valid_q && (resv_gran_q == cur_adr_s[31:RESV_GRAN_BITS]);

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    we_d   = bus.wb_we;
                    sel_d  = bus.wb_sel;
                    adr_d  = bus.wb_adr[31:2];
                    datw_d = bus.wb_datw;
                    cmd_d  = bus.ext_cmd;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d   = ST_TERM;
                        go_term_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.wb_cyc) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = ST_TERM;
                    go_term_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_TERM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_term_s) begin
            if (in_range_s) begin
                ack_d = 1'b1;
                if (cur_we_s) begin
                    if (cur_cmd_s == EXT_CMD_STCX) begin
                        pass_s       = resv_hit_s;
                        sram_en_s    = resv_hit_s;
                        resv_valid_d = 1'b0;
                    end else begin
                        sram_en_s = 1'b1;
                        if (resv_hit_s) begin
                            resv_valid_d = 1'b0;
                        end else begin
                            resv_valid_d = resv_valid_q;
                        end
                    end
                end else begin
                    sram_en_s = 1'b1;
                    if (cur_cmd_s == EXT_CMD_LARX) begin
                        resv_valid_d = 1'b1;
                        resv_gran_d  = cur_adr_s[31:RESV_GRAN_BITS];
                    end else begin
                        resv_valid_d = resv_valid_q;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            ack_d = 1'b0;
        end

        rsp_d[EXT_RSP_PASS_BIT] = pass_s;
        rsp_d[EXT_RSP_ERR_BIT]  = err_d;
    end

    // State, capture, reservation and termination registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            adr_q        <= 30'h0;
            datw_q       <= 32'h0000_0000;
            cmd_q        <= 8'h00;
            resv_valid_q <= 1'b0;
            resv_gran_q  <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rsp_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            datw_q       <= datw_d;
            cmd_q        <= cmd_d;
            resv_valid_q <= resv_valid_d;
            resv_gran_q  <= resv_gran_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rsp_q        <= rsp_d;
        end
    end

    wb_sram_bytewe #(
        .ADDR_BITS(ADDR_BITS)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .en    (sram_en_s),
        .we    (cur_we_s),
        .be    (cur_sel_s),
        .addr  (cur_adr_s[ADDR_BITS+1:2]),
        .wdata (cur_datw_s),
        .rdata (sram_rdata_s)
    );

    assign bus.wb_ack  = ack_q;
    assign bus.wb_err  = err_q;
    assign bus.wb_datr = sram_rdata_s;
    assign bus.ext_rsp = rsp_q;

endmodule

// File: tb/tb_wb_mem_target.sv
// Directed self-checking bench for wb_mem_target at WAIT_STATES = 1, 3 and 0.
module tb_wb_mem_target;

    logic clk;
    logic rst;

    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_datw;
    logic [7:0]  m_cmd;
    int          dsel;

    logic        t_ack, t_err;
    logic [31:0] t_datr;
    logic [7:0]  t_rsp;

    int n_tests;
    int n_fail;

    wb_mem_target_if bus0 ();
    wb_mem_target_if bus1 ();
    wb_mem_target_if bus2 ();

    assign bus0.wb_cyc = m_cyc & (dsel == 0);
    assign bus0.wb_stb = m_stb & (dsel == 0);
    assign bus0.wb_we = m_we;
    assign bus0.wb_sel = m_sel;
    assign bus0.wb_adr = m_adr;
    assign bus0.wb_datw = m_datw;
    assign bus0.ext_cmd = m_cmd;

    assign bus1.wb_cyc = m_cyc & (dsel == 1);
    assign bus1.wb_stb = m_stb & (dsel == 1);
    assign bus1.wb_we = m_we;
    assign bus1.wb_sel = m_sel;
    assign bus1.wb_adr = m_adr;
    assign bus1.wb_datw = m_datw;
    assign bus1.ext_cmd = m_cmd;

    assign bus2.wb_cyc = m_cyc & (dsel == 2);
    assign bus2.wb_stb = m_stb & (dsel == 2);
    assign bus2.wb_we = m_we;
    assign bus2.wb_sel = m_sel;
    assign bus2.wb_adr = m_adr;
    assign bus2.wb_datw = m_datw;
    assign bus2.ext_cmd = m_cmd;

    always_comb begin
        if (dsel == 0) begin
            t_ack = bus0.wb_ack; t_err = bus0.wb_err; t_datr = bus0.wb_datr; t_rsp = bus0.ext_rsp;
        end else if (dsel == 1) begin
            t_ack = bus1.wb_ack; t_err = bus1.wb_err; t_datr = bus1.wb_datr; t_rsp = bus1.ext_rsp;
        end else begin
            t_ack = bus2.wb_ack; t_err = bus2.wb_err; t_datr = bus2.wb_datr; t_rsp = bus2.ext_rsp;
        end
    end

    wb_mem_target #(.ADDR_BITS(10), .BASE_ADR(32'h0000_0000), .WAIT_STATES(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    wb_mem_target #(.ADDR_BITS(10), .BASE_ADR(32'h0000_0000), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    wb_mem_target #(.ADDR_BITS(10), .BASE_ADR(32'h0000_0000), .WAIT_STATES(0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer; lat is the cycle (0 = accept cycle) in which ack/err was seen, -1 on timeout.
    task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [7:0] cmd,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] rd, output logic [7:0] rsp);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_datw = dat; m_cmd = cmd;
        lat = -1; ack = 1'b0; err = 1'b0; rd = 32'h0; rsp = 8'h0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (t_ack || t_err) begin
                lat = n; ack = t_ack; err = t_err; rd = t_datr; rsp = t_rsp;
                break;
            end
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_cmd = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus0.wb_ack, bus0.wb_err, bus1.wb_ack, bus1.wb_err, bus2.wb_ack, bus2.wb_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ack_err: got %b expected 000000",
                {bus0.wb_ack, bus0.wb_err, bus1.wb_ack, bus1.wb_err, bus2.wb_ack, bus2.wb_err});
        end
        n_tests++;
        if (bus0.wb_datr !== 32'h0 || bus0.ext_rsp !== 8'h0) begin
            n_fail++; $display("FAIL reset_datr_rsp: got %h/%h expected 0/0", bus0.wb_datr, bus0.ext_rsp);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r;
        dsel = 0;
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (lat !== 2 || a !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL basic_wr_ack: got lat=%0d ack=%b err=%b expected lat=2 ack=1 err=0", lat, a, e);
        end
        xfer(1'b0, 4'hF, 32'h10, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (lat !== 2 || a !== 1'b1) begin
            n_fail++; $display("FAIL basic_rd_ack: got lat=%0d ack=%b expected lat=2 ack=1", lat, a);
        end
        n_tests++;
        if (d !== 32'hDEADBEEF || r !== 8'h00) begin
            n_fail++; $display("FAIL basic_rd_data: got %h rsp %h expected deadbeef rsp 00", d, r);
        end
        @(negedge clk);
        n_tests++;
        if (t_ack !== 1'b0 || t_datr !== 32'h0) begin
            n_fail++; $display("FAIL basic_after_term: got ack=%b datr=%h expected 0/0", t_ack, t_datr);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r;
        dsel = 0;
        xfer(1'b1, 4'hF, 32'h20, 32'h0, 8'h00, lat, a, e, d, r);
        xfer(1'b1, 4'b0101, 32'h20, 32'h11223344, 8'h00, lat, a, e, d, r);
        xfer(1'b0, 4'hF, 32'h20, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h00220044) begin
            n_fail++; $display("FAIL byte_lanes: got %h expected 00220044", d);
        end
    endtask

    task automatic test_range();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r;
        dsel = 0;
        xfer(1'b0, 4'hF, 32'h1000, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (lat !== 2 || e !== 1'b1 || a !== 1'b0 || r !== 8'h02 || d !== 32'h0) begin
            n_fail++; $display("FAIL range_rd_err: got lat=%0d err=%b ack=%b rsp=%h datr=%h expected 2/1/0/02/0",
                lat, e, a, r, d);
        end
        xfer(1'b1, 4'hF, 32'h1010, 32'h55555555, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (e !== 1'b1 || a !== 1'b0) begin
            n_fail++; $display("FAIL range_wr_err: got err=%b ack=%b expected 1/0", e, a);
        end
        xfer(1'b0, 4'hF, 32'h10, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL range_mem_unchanged: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_reservation();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r;
        dsel = 0;
        xfer(1'b1, 4'hF, 32'h40, 32'h12345678, 8'h00, lat, a, e, d, r);
        xfer(1'b0, 4'hF, 32'h40, 32'h0, 8'h01, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h12345678 || r !== 8'h00) begin
            n_fail++; $display("FAIL larx_data: got %h rsp %h expected 12345678 rsp 00", d, r);
        end
        xfer(1'b1, 4'hF, 32'h44, 32'hA5, 8'h02, lat, a, e, d, r);
        n_tests++;
        if (r !== 8'h01 || a !== 1'b1) begin
            n_fail++; $display("FAIL stcx_pass: got rsp=%h ack=%b expected 01/1", r, a);
        end
        xfer(1'b0, 4'hF, 32'h44, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h000000A5) begin
            n_fail++; $display("FAIL stcx_pass_data: got %h expected 000000a5", d);
        end
        xfer(1'b1, 4'hF, 32'h44, 32'h5A, 8'h02, lat, a, e, d, r);
        n_tests++;
        if (r !== 8'h00) begin
            n_fail++; $display("FAIL stcx_second: got rsp=%h expected 00", r);
        end
        xfer(1'b0, 4'hF, 32'h44, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h000000A5) begin
            n_fail++; $display("FAIL stcx_second_data: got %h expected 000000a5", d);
        end
        // Normal write in the same granule kills the reservation.
        xfer(1'b0, 4'hF, 32'h40, 32'h0, 8'h01, lat, a, e, d, r);
        xfer(1'b1, 4'hF, 32'h5C, 32'h99, 8'h00, lat, a, e, d, r);
        xfer(1'b1, 4'hF, 32'h40, 32'h77, 8'h02, lat, a, e, d, r);
        n_tests++;
        if (r !== 8'h00) begin
            n_fail++; $display("FAIL stcx_after_wr: got rsp=%h expected 00", r);
        end
        xfer(1'b0, 4'hF, 32'h40, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h12345678) begin
            n_fail++; $display("FAIL stcx_after_wr_data: got %h expected 12345678", d);
        end
        // Normal read leaves the reservation intact.
        xfer(1'b0, 4'hF, 32'h40, 32'h0, 8'h01, lat, a, e, d, r);
        xfer(1'b0, 4'hF, 32'h48, 32'h0, 8'h00, lat, a, e, d, r);
        xfer(1'b1, 4'hF, 32'h40, 32'hBEEF, 8'h02, lat, a, e, d, r);
        n_tests++;
        if (r !== 8'h01) begin
            n_fail++; $display("FAIL stcx_after_rd: got rsp=%h expected 01", r);
        end
        // sel = 0 write: no data change, but still clears the reservation.
        xfer(1'b0, 4'hF, 32'h40, 32'h0, 8'h01, lat, a, e, d, r);
        xfer(1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (a !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL sel0_ack: got ack=%b err=%b expected 1/0", a, e);
        end
        xfer(1'b1, 4'hF, 32'h40, 32'h1234, 8'h02, lat, a, e, d, r);
        n_tests++;
        if (r !== 8'h00) begin
            n_fail++; $display("FAIL stcx_after_sel0: got rsp=%h expected 00", r);
        end
        xfer(1'b0, 4'hF, 32'h40, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL sel0_data: got %h expected 0000beef", d);
        end
    endtask

    task automatic test_abort();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r; int acks;
        dsel = 1;
        xfer(1'b1, 4'hF, 32'h10, 32'hCAFEF00D, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (lat !== 4 || a !== 1'b1) begin
            n_fail++; $display("FAIL ws3_wr_ack: got lat=%0d ack=%b expected 4/1", lat, a);
        end
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF; m_adr = 32'h10; m_datw = 32'h0BAD0BAD; m_cmd = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (t_ack || t_err) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL abort_no_ack: got %0d terminations expected 0", acks);
        end
        xfer(1'b0, 4'hF, 32'h10, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'hCAFEF00D || lat !== 4) begin
            n_fail++; $display("FAIL abort_mem: got %h lat=%0d expected cafef00d lat=4", d, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r;
        dsel = 1;
        xfer(1'b1, 4'hF, 32'h14, 32'h00002222, 8'h00, lat, a, e, d, r);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF; m_adr = 32'h14; m_datw = 32'h00001111; m_cmd = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (t_ack !== 1'b0 || t_err !== 1'b0 || t_datr !== 32'h0 || t_rsp !== 8'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %b%b %h %h expected 00 0 0", t_ack, t_err, t_datr, t_rsp);
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        rst = 1'b0;
        xfer(1'b0, 4'hF, 32'h14, 32'h0, 8'h00, lat, a, e, d, r);
        n_tests++;
        if (d !== 32'h00002222 || lat !== 4 || a !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_after: got %h lat=%0d ack=%b expected 00002222 lat=4 ack=1", d, lat, a);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic a, e; logic [31:0] d; logic [7:0] r;
        logic [31:0] vals [4];
        int idx;
        vals[0] = 32'h1000_0001; vals[1] = 32'h2000_0002; vals[2] = 32'h3000_0003; vals[3] = 32'h4000_0004;
        dsel = 2;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 4'hF, 32'(i * 4), vals[i], 8'h00, lat, a, e, d, r);
            n_tests++;
            if (lat !== 1) begin
                n_fail++; $display("FAIL ws0_wr_lat: got %0d expected 1", lat);
            end
        end
        @(posedge clk); #1;
        idx = 0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 32'h0; m_cmd = 8'h00;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            n_tests++;
            if (t_ack !== ((n % 2) == 1)) begin
                n_fail++; $display("FAIL b2b_ack_c%0d: got %b expected %b", n, t_ack, (n % 2) == 1);
            end
            if ((n % 2) == 1) begin
                n_tests++;
                if (t_datr !== vals[idx]) begin
                    n_fail++; $display("FAIL b2b_data_%0d: got %h expected %h", idx, t_datr, vals[idx]);
                end
                idx++;
            end
            @(posedge clk); #1;
            if ((n % 2) == 1) m_adr = 32'(idx * 4);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        dsel = 0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 4'h0;
        m_adr = 32'h0; m_datw = 32'h0; m_cmd = 8'h00;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_range();
        test_reservation();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_mem_target.md
# wb_mem_target

Wishbone B4 classic-cycle responder (slave) that terminates the bus side of the core-to-bus bridge. It fronts an on-chip SRAM with byte-lane writes, a programmable wait-state count, and out-of-range error termination. It also carries the bridge's 8-bit extended command and response sideband, implementing a single larx/stcx reservation.

## Interface
Parameters:
- `ADDR_BITS`, 10: word-address width of the SRAM (2^ADDR_BITS × 32-bit words; default 4 KB).
- `BASE_ADR`, 32'h0000_0000: byte base address; must be aligned to the SRAM size.
- `WAIT_STATES`, 1: extra cycles inserted before termination (0–15).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wb_cyc` in 1: bus cycle valid.
- `wb_stb` in 1: strobe.
- `wb_we` in 1: 1 = write.
- `wb_sel` in 4: byte lane enables; bit n covers data[8n+7:8n].
- `wb_adr` in 32: byte address; bits [1:0] are ignored.
- `wb_datw` in 32: write data.
- `ext_cmd` in 8: 8'h00 normal, 8'h01 larx, 8'h02 stcx; other values are treated as normal.
- `wb_ack` out 1: normal termination.
- `wb_err` out 1: error termination.
- `wb_datr` out 32: read data.
- `ext_rsp` out 8: bit0 = stcx pass, bit1 = error, bits [7:2] = 0.

## Operation
- FSM states:
  - IDLE: accepts a request when `wb_cyc & wb_stb`.
  - WAIT: counts down `WAIT_STATES`.
  - TERM: drives ack or err for one cycle.
- On accept, capture `we`, `sel`, `adr`, `datw` and `cmd`.
- IDLE goes to WAIT when `WAIT_STATES > 0`, otherwise directly to TERM.
- WAIT goes to TERM when the counter reaches 0.
- TERM always returns to IDLE.
- Range check: `adr[31:ADDR_BITS+2]` must equal `BASE_ADR[31:ADDR_BITS+2]`. Out of range gives `wb_err = 1` and `ext_rsp[1] = 1`, with no SRAM access and no reservation change.
- Commit happens on the edge that enters TERM:
  - Write: update only the lanes selected by `sel`.
  - Read: register SRAM data into `wb_datr`.
- Reservation is a single valid bit plus granule `adr[31:5]` (32 B granule).
- larx: performs a read, sets valid and loads the granule.
- stcx: writes only if valid is set and the granule matches. Sets `ext_rsp[0]` = pass. Clears valid whether it passes or fails.
- Normal write whose granule matches the reservation: clears valid.
- Normal read: no effect on the reservation.
- Abort: if `wb_cyc` drops while in WAIT, go to IDLE with no commit and no reservation change.
- `wb_datr` and `ext_rsp` are valid only while ack or err is high; they read 0 otherwise.
- `wb_sel = 0` on a write: acked, no data changes, but the reservation rules still apply.

## Timing
- Reset values: `wb_ack = 0`, `wb_err = 0`, `wb_datr = 0`, `ext_rsp = 0`; FSM in IDLE; reservation invalid.
- SRAM contents are not reset.
- Latency: the first cycle `stb` is sampled high in IDLE is cycle 0. Ack or err is high in cycle `WAIT_STATES + 1` for exactly one cycle.
- Back-to-back: a master that holds `cyc & stb` with a new request in the cycle after TERM is accepted. Peak throughput is one transfer per `WAIT_STATES + 2` cycles.
- Request inputs are ignored outside IDLE except for `wb_cyc`, which is monitored for abort.
- Reset mid-operation: returns immediately to reset values. A write whose commit edge has not yet occurred is not performed.

## Structure
- Shared package (`a2wb_pkg`): `EXT_CMD_NORMAL`, `EXT_CMD_LARX`, `EXT_CMD_STCX`, the ext_rsp bit indices, and the reservation granule width (5). The bridge uses the same constants.
- Sub-module `wb_sram_bytewe`: a single-port array with a 4-bit byte write enable and a registered read port.
- FSM, counter, range check and reservation logic stay in `wb_mem_target`.

## Test plan
- Basic read/write, `WAIT_STATES = 1`: write 32'hDEADBEEF to 0x10 with `sel = 4'hF`, then read 0x10 → ack at cycle 2 both times; `datr = 32'hDEADBEEF`.
- Byte lanes: write 32'h11223344 to 0x20 with `sel = 4'b0101` over prior contents 0 → read returns 32'h00220044.
- Range error: read at `BASE + 4 × 2^ADDR_BITS` → `wb_err = 1`, `ext_rsp = 8'h02`, `wb_ack = 0`, `datr = 0`; memory unchanged.
- Reservation:
  - larx 0x40, then stcx 0x44 with 32'hA5 → `ext_rsp = 8'h01`, data written.
  - A second stcx 0x44 → `ext_rsp = 8'h00`, no write.
  - larx 0x40, normal write to 0x5C, then stcx 0x40 → fail.
- Abort and reset:
  - `WAIT_STATES = 3`, write issued, `cyc` dropped at cycle 2 → no ack, memory unchanged.
  - `rst` pulsed during WAIT → outputs 0, next request serviced normally.
- `WAIT_STATES = 0` back-to-back: four reads with `stb` held → ack every other cycle, correct data each time.
